// File: rtl/fc_output_mac.sv
// fc_output_mac: sequential biased multiply-accumulate for the final FC layer, Q8.8 in/out.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_start             begin an inference (sampled only in IDLE); latches i_bias
//   i_bias              per-neuron Q8.8 bias
//   i_in_valid/i_in_data/i_w_data  one activation x[k] with W[n][k] for every neuron
//   o_in_ready          high while accumulating
//   o_busy              high in every state except IDLE
//   o_out_valid         one-cycle pulse when o_out_values updates
//   o_out_values        saturated Q8.8 scores, neuron 0 first, held until next completion
module fc_output_mac #(
  parameter int SIZE     = 16,
  parameter int IN_SZ    = 4,
  parameter int LAYER_SZ = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic [0:LAYER_SZ-1][SIZE-1:0]    i_bias,
  input  logic                             i_in_valid,
  input  logic [SIZE-1:0]                  i_in_data,
  input  logic [0:LAYER_SZ-1][SIZE-1:0]    i_w_data,
  output logic                             o_in_ready,
  output logic                             o_busy,
  output logic                             o_out_valid,
  output logic [0:LAYER_SZ-1][SIZE-1:0]    o_out_values
);
  localparam int AW = 2*SIZE + $clog2(IN_SZ+1) + 1;
  localparam int KW = $clog2(IN_SZ+1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH, S_DONE} state_t;
  state_t                          r_state, w_next;
  logic [KW-1:0]                   r_k;
  logic signed [AW-1:0]            r_acc [LAYER_SZ];
  logic [0:LAYER_SZ-1][SIZE-1:0]   r_out;
  logic signed [AW-1:0]            w_bias_ext [LAYER_SZ];
  logic signed [2*SIZE-1:0]        w_prod [LAYER_SZ];
  logic signed [AW-1:0]            w_prod_ext [LAYER_SZ];
  logic signed [AW-1:0]            w_sh [LAYER_SZ];
  logic [0:LAYER_SZ-1][SIZE-1:0]   w_sat;
  logic                            w_beat;
  assign w_beat       = i_in_valid && r_state == S_ACCUM;
  assign o_in_ready   = r_state == S_ACCUM;
  assign o_busy       = r_state != S_IDLE;
  assign o_out_valid  = r_state == S_DONE;
  assign o_out_values = r_out;
  // Operands are sign-extended to 2*SIZE so the full Q16.16 product fits the low bits.
  // The >>> 8 on the signed accumulator floors toward -inf before clamping to Q8.8.
  always_comb begin
    for (int n = 0; n < LAYER_SZ; n++) begin
      w_bias_ext[n] = {{(AW-SIZE-8){i_bias[n][SIZE-1]}}, i_bias[n], 8'h00};
      w_prod[n]     = $signed({{SIZE{i_in_data[SIZE-1]}}, i_in_data})
                    * $signed({{SIZE{i_w_data[n][SIZE-1]}}, i_w_data[n]});
      w_prod_ext[n] = {{(AW-2*SIZE){w_prod[n][2*SIZE-1]}}, w_prod[n]};
      w_sh[n]       = r_acc[n] >>> 8;
      w_sat[n]      = w_sh[n] > MAXV ? {1'b0, {(SIZE-1){1'b1}}} :
                      w_sh[n] < MINV ? {1'b1, {(SIZE-1){1'b0}}} : w_sh[n][SIZE-1:0];
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = i_start ? S_ACCUM : S_IDLE;
      S_ACCUM:  w_next = (w_beat && r_k == KW'(IN_SZ-1)) ? S_FINISH : S_ACCUM;
      S_FINISH: w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_out   <= '0;
      for (int n = 0; n < LAYER_SZ; n++) r_acc[n] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) begin
        r_k <= '0;
        for (int n = 0; n < LAYER_SZ; n++) r_acc[n] <= w_bias_ext[n];
      end else if (w_beat) begin
        r_k <= r_k + KW'(1);
        for (int n = 0; n < LAYER_SZ; n++) r_acc[n] <= r_acc[n] + w_prod_ext[n];
      end
      if (r_state == S_FINISH) r_out <= w_sat;
    end
  end
endmodule

// File: tb/tb_fc_output_mac.sv
// tb_fc_output_mac: directed self-checking bench for fc_output_mac (IN_SZ=2, LAYER_SZ=2).
module tb_fc_output_mac;
  localparam int SIZE = 16, IN_SZ = 2, LAYER_SZ = 2;
  logic clk = 0, rst_n = 0, i_start = 0, i_in_valid = 0;
  logic [0:LAYER_SZ-1][SIZE-1:0] i_bias = '0, i_w_data = '0, o_out_values;
  logic [SIZE-1:0] i_in_data = '0;
  logic o_in_ready, o_busy, o_out_valid;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  fc_output_mac #(.SIZE(SIZE), .IN_SZ(IN_SZ), .LAYER_SZ(LAYER_SZ)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_bias(i_bias),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .i_w_data(i_w_data),
    .o_in_ready(o_in_ready), .o_busy(o_busy), .o_out_valid(o_out_valid),
    .o_out_values(o_out_values));
  // Inputs change on the falling edge; outputs are sampled on the falling edge too.
  task automatic start_inf(input logic [31:0] b);
    @(negedge clk); i_start = 1; i_bias = b;
    @(negedge clk); i_start = 0; i_bias = '0;
  endtask
  task automatic beat(input logic [15:0] x, input logic [31:0] w);
    i_in_valid = 1; i_in_data = x; i_w_data = w;
    @(negedge clk); i_in_valid = 0; i_in_data = '0; i_w_data = '0;
  endtask
  task automatic test_reset;
    #12;
    tests++; if ({o_in_ready, o_busy, o_out_valid} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: got %b want 000", {o_in_ready, o_busy, o_out_valid}); end
    tests++; if (o_out_values !== 32'h0) begin fails++; $display("FAIL reset_values: got %h want 00000000", o_out_values); end
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_basic;
    start_inf(32'h0000_0080);
    tests++; if ({o_in_ready, o_busy} !== 2'b11) begin fails++; $display("FAIL basic_ready: got %b want 11", {o_in_ready, o_busy}); end
    beat(16'h0100, 32'h0100_0200);
    beat(16'h0200, 32'h0080_FF00);
    tests++; if ({o_in_ready, o_busy, o_out_valid} !== 3'b010) begin fails++; $display("FAIL basic_finish: got %b want 010", {o_in_ready, o_busy, o_out_valid}); end
    @(negedge clk);
    tests++; if ({o_out_valid, o_out_values} !== {1'b1, 32'h0200_0080}) begin fails++; $display("FAIL basic_done: got %b/%h want 1/02000080", o_out_valid, o_out_values); end
    @(negedge clk);
    tests++; if ({o_busy, o_out_valid, o_out_values} !== {2'b00, 32'h0200_0080}) begin fails++; $display("FAIL basic_idle: got %b/%h want 00/02000080", {o_busy, o_out_valid}, o_out_values); end
  endtask
  task automatic test_saturation;
    start_inf(32'h0);
    beat(16'h7F00, 32'h7F00_8100);
    beat(16'h7F00, 32'h7F00_8100);
    @(negedge clk);
    tests++; if ({o_out_valid, o_out_values} !== {1'b1, 32'h7FFF_8000}) begin fails++; $display("FAIL saturation: got %b/%h want 1/7fff8000", o_out_valid, o_out_values); end
  endtask
  task automatic test_floor;
    start_inf(32'h0);
    beat(16'h0001, 32'hFFFF_0001);
    beat(16'h0000, 32'h0);
    @(negedge clk);
    tests++; if ({o_out_valid, o_out_values} !== {1'b1, 32'hFFFF_0000}) begin fails++; $display("FAIL floor: got %b/%h want 1/ffff0000", o_out_valid, o_out_values); end
  endtask
  task automatic test_stall_start;
    int pulses = 0;
    start_inf(32'h0000_0080);
    beat(16'h0100, 32'h0100_0200);
    i_start = 1;
    @(negedge clk); i_start = 0;
    tests++; if ({o_in_ready, o_busy, o_out_valid} !== 3'b110) begin fails++; $display("FAIL stall_hold: got %b want 110", {o_in_ready, o_busy, o_out_valid}); end
    @(negedge clk);
    beat(16'h0200, 32'h0080_FF00);
    tests++; if (o_out_valid !== 1'b0) begin fails++; $display("FAIL stall_early: got %b want 0", o_out_valid); end
    @(negedge clk);
    tests++; if ({o_out_valid, o_out_values} !== {1'b1, 32'h0200_0080}) begin fails++; $display("FAIL stall_done: got %b/%h want 1/02000080", o_out_valid, o_out_values); end
    for (int i = 0; i < 6; i++) begin @(negedge clk); pulses += int'(o_out_valid) + int'(o_busy); end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL start_ignored: got %0d busy/valid samples want 0", pulses); end
  endtask
  task automatic test_idle_beats;
    i_in_valid = 1; i_in_data = 16'h7F00; i_w_data = 32'h7F00_7F00;
    repeat (3) @(negedge clk);
    tests++; if ({o_in_ready, o_busy} !== 2'b00) begin fails++; $display("FAIL idle_ready: got %b want 00", {o_in_ready, o_busy}); end
    i_in_valid = 0;
    start_inf(32'h0000_0080);
    beat(16'h0100, 32'h0100_0200);
    beat(16'h0200, 32'h0080_FF00);
    @(negedge clk);
    tests++; if ({o_out_valid, o_out_values} !== {1'b1, 32'h0200_0080}) begin fails++; $display("FAIL idle_beats: got %b/%h want 1/02000080", o_out_valid, o_out_values); end
  endtask
  task automatic test_reset_mid;
    int spurious = 0;
    start_inf(32'h0000_0080);
    beat(16'h0100, 32'h0100_0200);
    #2 rst_n = 0;
    #1;
    tests++; if ({o_in_ready, o_busy, o_out_valid, o_out_values} !== 35'h0) begin fails++; $display("FAIL reset_mid: got %b/%h want 000/00000000", {o_in_ready, o_busy, o_out_valid}, o_out_values); end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); spurious += int'(o_out_valid) + int'(o_busy); end
    tests++; if (spurious !== 0) begin fails++; $display("FAIL reset_spurious: got %0d want 0", spurious); end
    start_inf(32'h0000_0080);
    beat(16'h0100, 32'h0100_0200);
    beat(16'h0200, 32'h0080_FF00);
    @(negedge clk);
    tests++; if ({o_out_valid, o_out_values} !== {1'b1, 32'h0200_0080}) begin fails++; $display("FAIL reset_rerun: got %b/%h want 1/02000080", o_out_valid, o_out_values); end
  endtask
  task automatic test_back_to_back;
    start_inf(32'h0);
    beat(16'h0001, 32'hFFFF_0001);
    beat(16'h0000, 32'h0);
    @(negedge clk);
    tests++; if ({o_out_valid, o_out_values} !== {1'b1, 32'hFFFF_0000}) begin fails++; $display("FAIL b2b_first: got %b/%h want 1/ffff0000", o_out_valid, o_out_values); end
    start_inf(32'h0);
    tests++; if ({o_in_ready, o_out_values} !== {1'b1, 32'hFFFF_0000}) begin fails++; $display("FAIL b2b_restart: got %b/%h want 1/ffff0000", o_in_ready, o_out_values); end
    beat(16'h7F00, 32'h7F00_8100);
    beat(16'h7F00, 32'h7F00_8100);
    tests++; if ({o_out_valid, o_out_values} !== {1'b0, 32'hFFFF_0000}) begin fails++; $display("FAIL b2b_hold: got %b/%h want 0/ffff0000", o_out_valid, o_out_values); end
    @(negedge clk);
    tests++; if ({o_out_valid, o_out_values} !== {1'b1, 32'h7FFF_8000}) begin fails++; $display("FAIL b2b_second: got %b/%h want 1/7fff8000", o_out_valid, o_out_values); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_stall_start;
    test_floor;
    test_idle_beats;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fc_output_mac.md
# fc_output_mac

Sequential multiply-accumulate engine for the final fully-connected layer of the classifier. It streams IN_SZ Q8.8 activations with their per-neuron weights and computes LAYER_SZ biased dot products. It saturates each result to Q8.8 and presents all LAYER_SZ scores in parallel, with a one-cycle valid pulse. Its output bus connects directly to the Softmax/argmax stage, which turns the scores into the class index.

## Interface
- SIZE, 16: data width; all data, weights and biases are signed Q8.8.
- IN_SZ, 4: number of input activations per inference (≥1).
- LAYER_SZ, 2: number of output neurons, and the number of scores passed to Softmax.
- clk  in  1: single clock; all state changes on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: begins an inference; sampled only in IDLE.
- bias  in  [0:LAYER_SZ-1][SIZE-1:0]: per-neuron bias; sampled on the accepted start cycle.
- in_valid  in  1: in_data/w_data carry one input element.
- in_data  in  SIZE: activation x[k].
- w_data  in  [0:LAYER_SZ-1][SIZE-1:0]: weights W[n][k] for every neuron n, for the same k.
- in_ready  out  1: high in ACCUM; a beat is accepted when in_valid && in_ready.
- busy  out  1: high in any state except IDLE.
- out_valid  out  1: one-cycle pulse when out_values is updated.
- out_values  out  [0:LAYER_SZ-1][SIZE-1:0]: saturated Q8.8 scores; held until the next completion.

## Operation
- States: IDLE, ACCUM, FINISH, DONE.
- IDLE, start=1 (accepted start):
  - each accumulator acc[n] ← sign-extended bias[n] << 8 (aligned to Q16.16);
  - k ← 0;
  - next state ACCUM.
- ACCUM, each accepted beat:
  - acc[n] += x·W[n] for every n; the product is a full 2·SIZE-bit signed Q16.16 value;
  - k increments.
- ACCUM, when the accepted beat is number IN_SZ (k == IN_SZ-1 at acceptance): next state FINISH.
- ACCUM, in_valid=0: hold state, accumulators and k.
- Accumulator width: 2·SIZE + clog2(IN_SZ+1) + 1 bits, so no internal overflow is possible.
- FINISH:
  - r[n] = acc[n] >>> 8, an arithmetic shift that floors toward -inf (no rounding);
  - saturate r[n] to [-32768, 32767], i.e. 0x8000..0x7FFF;
  - register the results into out_values;
  - next state DONE.
- DONE:
  - out_valid=1 for exactly this cycle;
  - next state IDLE unconditionally.
- start while busy is ignored and does not queue.
- in_valid outside ACCUM is ignored; in_ready=0 there.
- Operand order matches Softmax: out_values[0] is neuron 0.

## Timing
- Reset values: state=IDLE, in_ready=0, busy=0, out_valid=0, out_values all 0, accumulators 0, k=0.
- Reset asserted mid-inference aborts immediately. No out_valid pulse is produced. The first start after reset release begins a fresh inference.
- Start accepted at cycle t: in_ready=1 from t+1.
- Last beat accepted at cycle u:
  - in_ready=0 from u+1;
  - FINISH at u+1;
  - out_values update and out_valid=1 at u+2;
  - IDLE at u+3.
- Minimum inference time with no stalls: IN_SZ+3 cycles from start to the next start accepted.
- out_values changes only on the edge that enters DONE. It is stable at all other times, including during the next inference.
- busy rises the cycle after the accepted start and falls the cycle after out_valid.

## Test plan
- Basic (IN_SZ=2, LAYER_SZ=2):
  - stimulus: x={0x0100, 0x0200}, W[0]={0x0100, 0x0080}, W[1]={0x0200, 0xFF00}, bias={0x0000, 0x0080};
  - response: out_values={0x0200, 0x0080}; out_valid exactly 2 cycles after the last beat; Softmax connected downstream gives class_out=0.
- Saturation:
  - x={0x7F00, 0x7F00} with W[0]={0x7F00, 0x7F00} → 0x7FFF;
  - same x with W[1]={0x8100, 0x8100} → 0x8000.
- Floor truncation:
  - x={0x0001, 0x0000}, W[0]={0xFFFF, 0}, bias 0 → out_values[0]=0xFFFF (-1 LSB, not 0).
- Stalls and ignored inputs:
  - in_valid toggled 1,0,0,1 during the basic vector → same results as the basic case;
  - start pulsed during ACCUM → ignored; exactly one out_valid;
  - in_valid beats while IDLE → no effect on the next result.
- Reset mid-operation:
  - drop rst_n after one beat → all outputs 0 and IDLE;
  - rerun the basic vector → correct results; no spurious out_valid.
- Back-to-back inferences:
  - two vectors with start re-asserted the cycle after out_valid → second result correct;
  - first out_values held until the second DONE.
